// File: rtl/reg_bus_sequencer_pkg.sv
// Shared definitions for the register-bus sequencer: FSM state encoding,
// default geometry and the index range helper.
package reg_bus_sequencer_pkg;

    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREGS = 8;

    // The register array top decodes the same 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic idx_in_range(input logic [31:0] idx, input logic [31:0] nregs);
        return idx < nregs;
    endfunction

endpackage

// File: rtl/reg_bus_sequencer_idx_decoder.sv
// Index-to-one-hot decoder for register strobes. The output is all zero when
// disabled or when the index does not name an existing register.
module idx_decoder #(
    parameter int IDX_W = 3,
    parameter int NREGS = 8
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Controller end of the shared tri-state register bus: runs one move per
// request (reg->reg, imm->reg or read-back) with registered strobes.
module reg_bus_sequencer
    import reg_bus_sequencer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_src,
    input  logic [IDX_W-1:0] req_dst,
    input  logic             req_imm_en,
    input  logic [DEPTH-1:0] req_imm,
    input  logic             req_wr_en,
    output logic [NREGS-1:0] oe_sel,
    output logic [NREGS-1:0] we_sel,
    input  logic [DEPTH-1:0] bus_in,
    output logic [DEPTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DEPTH-1:0] rsp_data,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic             wr_en_q, wr_en_d;
    logic             err_q, err_d;
    logic [DEPTH-1:0] hold_q, hold_d;

    logic [NREGS-1:0] oe_sel_q, oe_sel_d;
    logic [NREGS-1:0] we_sel_q, we_sel_d;
    logic             bus_oe_q, bus_oe_d;
    logic [DEPTH-1:0] bus_out_q, bus_out_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DEPTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             oe_en_d, we_en_d;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        wr_en_d = wr_en_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    src_d   = req_src;
                    dst_d   = req_dst;
                    wr_en_d = req_wr_en;
                    err_d   = (!req_imm_en && !idx_in_range(32'(req_src), NREGS)) ||
                              (req_wr_en && !idx_in_range(32'(req_dst), NREGS));
                    if (req_imm_en) begin
                        hold_d  = req_imm;
                        state_d = req_wr_en ? ST_WRITE : ST_RESP;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                // Nothing drives the bus for a missing source, so load a clean zero.
                hold_d  = idx_in_range(32'(src_q), NREGS) ? bus_in : '0;
                state_d = wr_en_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered and registered, so the
    // strobes come straight from flops.
    assign oe_en_d = (state_d == ST_READ);
    assign we_en_d = (state_d == ST_WRITE);

    idx_decoder #(.IDX_W(IDX_W), .NREGS(NREGS)) u_oe_dec (
        .idx    (src_d),
        .en     (oe_en_d),
        .onehot (oe_sel_d)
    );

    idx_decoder #(.IDX_W(IDX_W), .NREGS(NREGS)) u_we_dec (
        .idx    (dst_d),
        .en     (we_en_d),
        .onehot (we_sel_d)
    );

    assign bus_oe_d    = we_en_d;
    assign bus_out_d   = we_en_d ? hold_d : '0;
    assign rsp_valid_d = (state_d == ST_RESP);
    assign rsp_data_d  = rsp_valid_d ? hold_d : '0;
    assign rsp_err_d   = rsp_valid_d && err_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            wr_en_q     <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            oe_sel_q    <= '0;
            we_sel_q    <= '0;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            wr_en_q     <= wr_en_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            oe_sel_q    <= oe_sel_d;
            we_sel_q    <= we_sel_d;
            bus_oe_q    <= bus_oe_d;
            bus_out_q   <= bus_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign oe_sel    = oe_sel_q;
    assign we_sel    = we_sel_q;
    assign bus_oe    = bus_oe_q;
    assign bus_out   = bus_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
